// File: rtl/row_token_gen_pkg.sv
// Shared definitions for the row token generator.
// Holds the default row count, the matching address width and the
// encoding of the scan FSM states.
package row_token_gen_pkg;

    localparam int NROWS_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/row_token_gen_lsb_pick.sv
// row_lsb_pick: combinational lowest-set-bit selector.
// Ports:
//   mask   - input row mask
//   onehot - one-hot of the lowest set bit of mask (zero if mask is zero)
//   idx    - binary index of that bit (zero if mask is zero)
//   any    - mask has at least one bit set
module row_lsb_pick
    import row_token_gen_pkg::*;
#(
    parameter int NROWS  = NROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [NROWS-1:0]  mask,
    output logic [NROWS-1:0]  onehot,
    output logic [ADDR_W-1:0] idx,
    output logic              any
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = mask & (~mask + {{(NROWS-1){1'b0}}, 1'b1});
    assign any    = |mask;

    // Scan from the top down so the lowest set bit wins last.
    always_comb begin
        idx = '0;
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (mask[i]) idx = ADDR_W'(i);
        end
    end

endmodule

// File: rtl/row_token_gen.sv
// row_token_gen: scans a captured row hit map and hands out a one-hot
// token per hit row, lowest index first, one grant per acknowledged cycle.
// Ports:
//   Clk, Reset_b - clock, asynchronous active-low reset
//   Start        - request to scan Hit (ignored while Busy)
//   Hit          - row hit flags, captured on accepted Start
//   Ack          - downstream consumed the current token
//   Token        - one-hot row grant, zero when TokenValid is low
//   TokenValid   - Token holds a grant
//   RowAddr      - binary index of the granted row, zero when idle
//   Busy         - scan in progress (low only in IDLE)
//   Done         - one-cycle pulse at end of scan
//   dbg_state    - current FSM state, for observation only
//
// Handshake: a grant is presented while TokenValid=1 and is consumed on
// a rising edge where Ack=1; Ack with TokenValid=0 has no effect.
module row_token_gen
    import row_token_gen_pkg::*;
#(
    parameter int NROWS  = NROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_b,
    input  logic              Start,
    input  logic [NROWS-1:0]  Hit,
    input  logic              Ack,
    output logic [NROWS-1:0]  Token,
    output logic              TokenValid,
    output logic [ADDR_W-1:0] RowAddr,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        dbg_state
);

    state_t              state, state_nxt;
    logic [NROWS-1:0]    pending, pending_nxt;
    logic [NROWS-1:0]    token_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                valid_nxt, busy_nxt, done_nxt;

    logic [NROWS-1:0]    pick_mask, pick_onehot;
    logic [ADDR_W-1:0]   pick_idx;
    logic                pick_any;

    // In IDLE the picker looks at the incoming hit map so the first grant
    // is ready the cycle after Start; while issuing it looks at what
    // remains once the current grant is retired.
    assign pick_mask = (state == ST_IDLE) ? Hit : (pending & ~Token);

    row_lsb_pick #(
        .NROWS  (NROWS),
        .ADDR_W (ADDR_W)
    ) u_pick (
        .mask   (pick_mask),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign dbg_state = state;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        token_nxt   = Token;
        addr_nxt    = RowAddr;
        valid_nxt   = TokenValid;
        busy_nxt    = Busy;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_nxt  = 1'b0;
                valid_nxt = 1'b0;
                token_nxt = '0;
                addr_nxt  = '0;
                if (Start) begin
                    pending_nxt = Hit;
                    busy_nxt    = 1'b1;
                    if (pick_any) begin
                        state_nxt = ST_ISSUE;
                        token_nxt = pick_onehot;
                        addr_nxt  = pick_idx;
                        valid_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_FIN;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (Ack) begin
                    pending_nxt = pick_mask;
                    if (pick_any) begin
                        token_nxt = pick_onehot;
                        addr_nxt  = pick_idx;
                    end else begin
                        state_nxt = ST_FIN;
                        token_nxt = '0;
                        addr_nxt  = '0;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_FIN: begin
                state_nxt   = ST_IDLE;
                pending_nxt = '0;
                busy_nxt    = 1'b0;
            end
            default: begin
                state_nxt   = ST_IDLE;
                pending_nxt = '0;
                token_nxt   = '0;
                addr_nxt    = '0;
                valid_nxt   = 1'b0;
                busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            state      <= ST_IDLE;
            pending    <= '0;
            Token      <= '0;
            RowAddr    <= '0;
            TokenValid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            Token      <= token_nxt;
            RowAddr    <= addr_nxt;
            TokenValid <= valid_nxt;
            Busy       <= busy_nxt;
            Done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_row_token_gen.sv
// Testbench for row_token_gen: directed scenarios with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_row_token_gen;

    localparam int NROWS  = 16;
    localparam int ADDR_W = 4;

    // ---------------- clock / reset ----------------
    logic              Clk = 1'b0;
    logic              Reset_b;
    logic              Start;
    logic [NROWS-1:0]  Hit;
    logic              Ack;
    logic [NROWS-1:0]  Token;
    logic              TokenValid;
    logic [ADDR_W-1:0] RowAddr;
    logic              Busy;
    logic              Done;
    logic [1:0]        dbg_state;

    always #5 Clk = ~Clk;

    row_token_gen #(.NROWS(NROWS), .ADDR_W(ADDR_W)) dut (
        .Clk        (Clk),
        .Reset_b    (Reset_b),
        .Start      (Start),
        .Hit        (Hit),
        .Ack        (Ack),
        .Token      (Token),
        .TokenValid (TokenValid),
        .RowAddr    (RowAddr),
        .Busy       (Busy),
        .Done       (Done),
        .dbg_state  (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The scan is a list of rows still to grant; the head is the current
    // token. After the list drains there is one finishing cycle.
    int m_q[$];
    bit m_fin;

    always @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            m_q.delete();
            m_fin = 1'b0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_q.size() > 0) begin
            if (Ack) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_fin = 1'b1;
            end
        end else if (Start) begin
            for (int k = 0; k < NROWS; k++) if (Hit[k]) m_q.push_back(k);
            if (m_q.size() == 0) m_fin = 1'b1;
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] got_q[$];

    always @(negedge Clk) begin
        logic        e_valid;
        logic [31:0] e_addr, e_token;
        e_valid = (m_q.size() > 0);
        e_addr  = e_valid ? 32'(m_q[0]) : 32'd0;
        e_token = e_valid ? (32'd1 << m_q[0]) : 32'd0;
        check("model_valid", 32'(TokenValid), 32'(e_valid));
        check("model_token", 32'(Token), e_token);
        check("model_addr",  32'(RowAddr), e_addr);
        check("model_busy",  32'(Busy), 32'(e_valid | m_fin));
        check("model_done",  32'(Done), 32'(m_fin));
        // Token must be consistent with RowAddr and never multi-hot.
        check("token_vs_addr", 32'(Token), TokenValid ? (32'd1 << RowAddr) : 32'd0);
        // Inputs change just after the rising edge, so Ack here is the
        // value the next edge will see.
        if (TokenValid && Ack) got_q.push_back(RowAddr);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_scan(input logic [NROWS-1:0] h, input logic a);
        Start = 1'b1;
        Hit   = h;
        Ack   = a;
        cyc();
        Start = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [15:0] tok,
                              input logic [3:0] addr, input logic tv,
                              input logic bsy, input logic dn);
        check({name, "_token"}, 32'(Token), 32'(tok));
        check({name, "_addr"},  32'(RowAddr), 32'(addr));
        check({name, "_valid"}, 32'(TokenValid), 32'(tv));
        check({name, "_busy"},  32'(Busy), 32'(bsy));
        check({name, "_done"},  32'(Done), 32'(dn));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset_b = 1'b0;
        Start   = 1'b0;
        Hit     = '0;
        Ack     = 1'b0;
        cyc();
        expect_out("reset", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        Reset_b = 1'b1;

        // Hit=8421 with continuous Ack
        start_scan(16'h8421, 1'b1);
        expect_out("s8421_g0", 16'h0001, 4'd0,  1'b1, 1'b1, 1'b0); cyc();
        expect_out("s8421_g1", 16'h0020, 4'd5,  1'b1, 1'b1, 1'b0); cyc();
        expect_out("s8421_g2", 16'h0400, 4'd10, 1'b1, 1'b1, 1'b0); cyc();
        expect_out("s8421_g3", 16'h8000, 4'd15, 1'b1, 1'b1, 1'b0); cyc();
        expect_out("s8421_fin", 16'h0, 4'd0, 1'b0, 1'b1, 1'b1);    cyc();
        expect_out("s8421_idle", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Empty hit map
        start_scan(16'h0000, 1'b1);
        expect_out("empty_fin", 16'h0, 4'd0, 1'b0, 1'b1, 1'b1); cyc();
        expect_out("empty_idle", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Hit=0006 with three stalled cycles
        start_scan(16'h0006, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_out("stall_hold", 16'h0002, 4'd1, 1'b1, 1'b1, 1'b0);
            if (i == 3) Ack = 1'b1;
            cyc();
        end
        expect_out("stall_g1", 16'h0004, 4'd2, 1'b1, 1'b1, 1'b0); cyc();
        expect_out("stall_fin", 16'h0, 4'd0, 1'b0, 1'b1, 1'b1);    cyc();
        expect_out("stall_idle", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Start during active scan is ignored
        start_scan(16'h0003, 1'b1);
        Start = 1'b1; Hit = 16'hFFFF;
        expect_out("busy_g0", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0); cyc();
        Start = 1'b0;
        expect_out("busy_g1", 16'h0002, 4'd1, 1'b1, 1'b1, 1'b0); cyc();
        expect_out("busy_fin", 16'h0, 4'd0, 1'b0, 1'b1, 1'b1);   cyc();
        expect_out("busy_idle", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset mid-scan
        start_scan(16'h00F0, 1'b1);
        expect_out("rst_g0", 16'h0010, 4'd4, 1'b1, 1'b1, 1'b0); cyc();
        expect_out("rst_g1", 16'h0020, 4'd5, 1'b1, 1'b1, 1'b0);
        Reset_b = 1'b0;
        #1;
        expect_out("rst_async", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_out("rst_hold", 16'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        Reset_b = 1'b1;
        start_scan(16'h0001, 1'b1);
        expect_out("rst_new_g0", 16'h0001, 4'd0, 1'b1, 1'b1, 1'b0); cyc();
        expect_out("rst_new_fin", 16'h0, 4'd0, 1'b0, 1'b1, 1'b1);  cyc();
        Ack = 1'b0;

        // Random hit maps with random stalls
        for (int t = 0; t < 24; t++) begin
            logic [NROWS-1:0] h;
            bit finished;
            h = NROWS'($urandom_range(0, 16'hFFFF));
            if (t == 0) h = '0;
            if (t == 1) h = '1;
            exp_q.delete();
            got_q.delete();
            for (int k = 0; k < NROWS; k++) if (h[k]) exp_q.push_back(ADDR_W'(k));
            start_scan(h, 1'($urandom_range(0, 1)));
            finished = 1'b0;
            for (int c = 0; c < 200; c++) begin
                Ack = 1'($urandom_range(0, 1));
                cyc();
                if (!Busy) begin
                    finished = 1'b1;
                    break;
                end
            end
            check("rand_timeout", 32'(finished), 32'd1);
            check("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check("rand_order", 32'(got_q[i]), 32'(exp_q[i]));
        end

        Ack = 1'b0;
        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/row_token_gen.md
ROW_TOKEN_GEN -- requirements
Module: row_token_gen

Interface
REQ-001 SHALL have parameter NROWS, default 16, number of rows in the token chain (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_W, default 4, equal to log2(NROWS).
REQ-003 SHALL have port Clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port Reset_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  one-cycle request to scan a new hit map.
REQ-006 SHALL have port Hit  input  NROWS  row hit flags, bit k = row k, sampled only on accepted Start.
REQ-007 SHALL have port Ack  input  1  downstream consumed the current token.
REQ-008 SHALL have port Token  output  NROWS  one-hot row token, bit k grants row k.
REQ-009 SHALL have port TokenValid  output  1  Token holds a valid grant.
REQ-010 SHALL have port RowAddr  output  ADDR_W  binary index of the set Token bit.
REQ-011 SHALL have port Busy  output  1  scan in progress.
REQ-012 SHALL have port Done  output  1  one-cycle pulse at end of scan.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, FIN.
REQ-014 IDLE: Start=1 SHALL capture Hit into a registered Pending mask and go to ISSUE if Hit!=0, else to FIN.
REQ-015 ISSUE: Token SHALL equal the lowest set bit of Pending, registered; TokenValid=1; Busy=1.
REQ-016 ISSUE with Ack=1 SHALL clear the granted bit in Pending; next Token is the next lowest bit on the following cycle (one grant per cycle at continuous Ack).
REQ-017 ISSUE with Ack=1 on the last Pending bit SHALL go to FIN with TokenValid=0 and Token=0 next cycle.
REQ-018 ISSUE with Ack=0 SHALL hold Token, RowAddr and TokenValid unchanged.
REQ-019 FIN SHALL assert Done for exactly one cycle, Busy=1, then return to IDLE.
REQ-020 Start while Busy=1 SHALL be ignored; Pending not modified.
REQ-021 Token SHALL be zero whenever TokenValid=0; never more than one bit set.
REQ-022 RowAddr SHALL be registered together with Token and equal its index; 0 when TokenValid=0.
REQ-023 Latency: Start accepted in cycle n -> first TokenValid in cycle n+1; empty Hit -> Done in cycle n+1.
REQ-024 Rows SHALL be granted strictly in ascending index order; row NROWS-1 last, no wrap to row 0.
REQ-025 Ack while TokenValid=0 SHALL be ignored.
REQ-026 Busy SHALL be 0 only in IDLE.

Reset
REQ-027 Reset_b=0 SHALL asynchronously force state IDLE, Pending=0, Token=0, TokenValid=0, RowAddr=0, Busy=0, Done=0.
REQ-028 Reset mid-scan SHALL discard remaining Pending bits without a Done pulse.
REQ-029 After Reset_b release, the first rising edge SHALL accept Start.

Structure
REQ-030 Shared package SHALL hold NROWS/ADDR_W defaults and the FSM state encoding.
REQ-031 A sub-module row_lsb_pick SHALL compute lowest-set-bit one-hot and its binary index from an NROWS mask (combinational).
REQ-032 Only registered values SHALL drive Token, TokenValid, RowAddr, Busy, Done.

Verification
REQ-033 Hit=16'h8421, Start, Ack held 1 -> Token 0x0001,0x0020,0x0400,0x8000 on consecutive cycles, RowAddr 0,5,10,15, Done one cycle after last.
REQ-034 Hit=16'h0000, Start -> no TokenValid, Done=1 exactly one cycle later, Busy=1 that cycle only.
REQ-035 Hit=16'h0006, Ack=0 for 3 cycles then 1 -> Token 0x0002 held 4 cycles, then 0x0004, then Done.
REQ-036 Start with Hit=16'hFFFF during active scan of 16'h0003 -> only rows 0,1 granted, second Start ignored.
REQ-037 Reset_b low after second grant of 16'h00F0 -> all outputs 0 immediately, no Done; new Start Hit=16'h0001 -> Token 0x0001.
REQ-038 Random Hit maps with random Ack stalls -> granted RowAddr sequence equals ascending set-bit list of Hit; Token always one-hot or zero and consistent with RowAddr.
